// File: rtl/a_sqrtb_arbiter.sv
// a_sqrtb_arbiter: round-robin arbiter that shares one a_sqrtb engine
// (y = a * floor(sqrt(b))) among N_REQ requesters and returns each result to
// the requester that issued the job.
// Optional build macro: A_SQRTB_ARB_TIMEOUT_EN adds a WAIT-state timeout
// that reports err_o/done_o with y_o = 12'hFFF and re-drains the engine.
`timescale 1ns/1ps

module a_sqrtb_arbiter #(
    parameter int N_REQ        = 2,
    parameter int DRAIN_CYCLES = 64,
    parameter int TIMEOUT      = 255
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [N_REQ-1:0]   req_i,
    input  logic [8*N_REQ-1:0] a_i,
    input  logic [8*N_REQ-1:0] b_i,
    output logic [N_REQ-1:0]   gnt_o,
    output logic [N_REQ-1:0]   done_o,
    output logic [N_REQ-1:0]   err_o,
    output logic [11:0]        y_o,
    output logic               busy_o,
    output logic [7:0]         eng_a_o,
    output logic [7:0]         eng_b_o,
    output logic               eng_in_ready_o,
    input  logic [11:0]        eng_y_i,
    input  logic               eng_y_ready_i
);

    localparam logic [2:0] S_DRAIN  = 3'd0;
    localparam logic [2:0] S_IDLE   = 3'd1;
    localparam logic [2:0] S_ISSUE  = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;

    logic [2:0]       r_state;
    logic [15:0]      r_drain_cnt;
    logic [1:0]       r_ptr;
    logic [1:0]       r_gidx;
    logic [N_REQ-1:0] r_gnt;
    logic [N_REQ-1:0] r_done;
    logic [11:0]      r_y;
    logic             r_busy;
    logic [7:0]       r_eng_a;
    logic [7:0]       r_eng_b;
    logic             r_eng_start;

    // Requests and operands widened to the 4-requester maximum so the
    // grant index can select them without width juggling.
    logic [3:0]       w_req4;
    logic [31:0]      w_a32;
    logic [31:0]      w_b32;
    logic             w_found;
    logic [1:0]       w_try;
    logic [1:0]       w_gidx;
    logic [N_REQ-1:0] w_gnt_oh;
    logic [N_REQ-1:0] w_cur_oh;

    assign w_req4   = 4'(req_i);
    assign w_a32    = 32'(a_i);
    assign w_b32    = 32'(b_i);
    assign w_gnt_oh = N_REQ'(4'b0001 << w_gidx);
    assign w_cur_oh = N_REQ'(4'b0001 << r_gidx);

`ifdef A_SQRTB_ARB_TIMEOUT_EN
    logic [15:0]      r_tmo_cnt;
    logic [N_REQ-1:0] r_err;
    assign err_o = r_err;
`else
    assign err_o = '0;
`endif

    assign gnt_o          = r_gnt;
    assign done_o         = r_done;
    assign y_o            = r_y;
    assign busy_o         = r_busy;
    assign eng_a_o        = r_eng_a;
    assign eng_b_o        = r_eng_b;
    assign eng_in_ready_o = r_eng_start;

    // Round-robin search: first requesting index after the last grant, wrapping.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        w_found = 1'b0;
        w_gidx  = r_ptr;
        w_try   = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            w_try = 2'((int'(r_ptr) + off) % N_REQ);
            if (!w_found && w_req4[w_try]) begin
                w_found = 1'b1;
                w_gidx  = w_try;
            end
        end
    end

    // Sequencer state, operand capture and registered output pulses.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_ni) begin
            r_state     <= S_DRAIN;
            r_drain_cnt <= '0;
            r_ptr       <= 2'(N_REQ - 1);
            r_gidx      <= '0;
            r_gnt       <= '0;
            r_done      <= '0;
            r_y         <= '0;
            r_busy      <= 1'b0;
            r_eng_a     <= '0;
            r_eng_b     <= '0;
            r_eng_start <= 1'b0;
`ifdef A_SQRTB_ARB_TIMEOUT_EN
            r_err       <= '0;
            r_tmo_cnt   <= '0;
`endif
        end else begin
            // Pulse outputs default low; each is raised for one cycle below.
            r_gnt       <= '0;
            r_done      <= '0;
            r_eng_start <= 1'b0;
`ifdef A_SQRTB_ARB_TIMEOUT_EN
            r_err       <= '0;
`endif
            case (r_state)
                S_DRAIN: begin
                    // The engine has no reset: let any in-flight job finish unseen.
                    if (r_drain_cnt == 16'(DRAIN_CYCLES - 1)) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 16'd1;
                        r_busy      <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (w_found) begin
                        r_eng_a     <= w_a32[{w_gidx, 3'b000} +: 8];
                        r_eng_b     <= w_b32[{w_gidx, 3'b000} +: 8];
                        r_gidx      <= w_gidx;
                        r_gnt       <= w_gnt_oh;
                        r_eng_start <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_SETTLE;
                end
                S_SETTLE: begin
                    // Engine drops its stale y_ready during this cycle.
                    r_state <= S_WAIT;
`ifdef A_SQRTB_ARB_TIMEOUT_EN
                    r_tmo_cnt <= '0;
`endif
                end
                S_WAIT: begin
                    if (eng_y_ready_i) begin
                        r_y     <= eng_y_i;
                        r_done  <= w_cur_oh;
                        r_ptr   <= r_gidx;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
`ifdef A_SQRTB_ARB_TIMEOUT_EN
                    else if (r_tmo_cnt == 16'(TIMEOUT - 1)) begin
                        r_y         <= 12'hFFF;
                        r_done      <= w_cur_oh;
                        r_err       <= w_cur_oh;
                        r_ptr       <= r_gidx;
                        r_drain_cnt <= '0;
                        r_state     <= S_DRAIN;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 16'd1;
                    end
`endif
                end
                default: begin
                    r_state     <= S_DRAIN;
                    r_drain_cnt <= '0;
                    r_busy      <= 1'b1;
                end
            endcase
        end
    end

endmodule
